// File: rtl/cronometru_pkg.sv
// cronometru_pkg: shared state codes and default parameters for the stopwatch controller
`timescale 1ns/100ps
package cronometru_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_LAP    = 2'd3
    } state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF = 3;
endpackage

// File: rtl/cronometru_debounce.sv
// cronometru_debounce: 2-FF synchronizer, stability debouncer and rising-edge pulse for one button
// Ports: clk_out clock, reset async active-high, btn raw button, pulse one-cycle press pulse
`timescale 1ns/100ps
module cronometru_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 3
) (
    input  logic clk_out,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic sync1_q, sync2_q;
    logic level_q, level_d, prev_q, pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        level_d = level_q;
        cnt_d = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
            else cnt_d = cnt_q + 1'b1;
        end
        pulse_d = level_q & ~prev_q;
    end
    // level and prev reset to 1 so a button held through reset never pulses
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            pulse_q <= pulse_d;
        end
    end
    assign pulse = pulse_q;
endmodule

// File: rtl/cronometru_control.sv
// cronometru_control: turns start/stop and lap/reset buttons into pauza, clr and lap_hold for the stopwatch
// Ports: clk_out clock, reset async active-high, btn_ss/btn_lr raw buttons,
//        pauza counter freeze, clr one-cycle clear, lap_hold display freeze, state FSM state
`timescale 1ns/100ps
module cronometru_control
    import cronometru_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       pauza,
    output logic       clr,
    output logic       lap_hold,
    output logic [1:0] state
);
    logic ss_p, lr_p;
    state_t state_q, state_d;
    logic pauza_q, pauza_d, clr_q, clr_d, lap_hold_q, lap_hold_d;
    cronometru_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ss (
        .clk_out(clk_out), .reset(reset), .btn(btn_ss), .pulse(ss_p)
    );
    cronometru_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_lr (
        .clk_out(clk_out), .reset(reset), .btn(btn_lr), .pulse(lr_p)
    );
    // ss_p has priority; a simultaneous lr_p is dropped
    always_comb begin
        state_d = state_q;
        clr_d = 1'b0;
        if (ss_p) begin
            state_d = (state_q == ST_RUN || state_q == ST_LAP) ? ST_PAUSED : ST_RUN;
        end else if (lr_p) begin
            state_d = (state_q == ST_RUN) ? ST_LAP :
                      (state_q == ST_LAP) ? ST_RUN : ST_IDLE;
            clr_d = (state_q == ST_IDLE || state_q == ST_PAUSED);
        end
        pauza_d = (state_d == ST_IDLE || state_d == ST_PAUSED);
        lap_hold_d = (state_d == ST_LAP);
    end
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pauza_q    <= 1'b1;
            clr_q      <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pauza_q    <= pauza_d;
            clr_q      <= clr_d;
            lap_hold_q <= lap_hold_d;
        end
    end
    assign pauza = pauza_q;
    assign clr = clr_q;
    assign lap_hold = lap_hold_q;
    assign state = state_q;
endmodule
